matmul_apb_arbiter: RTL
=======================

Name: matmul_apb_arbiter

Overview:
- Two-requester APB master front end that shares the single matmul APB slave between independent bus masters, for example the stimulus driver and a result-readback engine.
- Arbitrates round-robin and drives the APB SETUP/ACCESS phases.
- Locks the slave to the requester that launched a computation (write of START to the control register) until the DUT busy flag completes a rise/fall cycle or a start timeout expires.

Parameters:
- ADDR_WIDTH, 16, APB address width.
- BUS_WIDTH, 64, APB data width.
- MAX_DIM, 4, pstrb width.
- CTRL_ADDR, 16'h0000, address of the matmul control register.
- START_BIT, 0, bit index of START inside pwdata.
- START_TIMEOUT, 16, maximum cycles to wait for busy to rise after START before releasing the lock.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-high reset (port name kept as in the codebase; asserted = 1).
- req_valid  in  2  per-requester transfer request; held with its fields stable until the matching req_done.
- req_addr  in  2*ADDR_WIDTH  request address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_write  in  2  1 = write, 0 = read.
- req_wdata  in  2*BUS_WIDTH  write data.
- req_strb  in  2*MAX_DIM  write strobes.
- req_done  out  2  one-cycle completion pulse to the owning requester.
- req_rdata  out  BUS_WIDTH  read data, valid while req_done is high; holds its value otherwise.
- req_err  out  1  captured pslverr, valid while req_done is high.
- grant  out  2  one-hot current owner; 0 when idle and unlocked.
- locked  out  1  slave is reserved for grant owner during a computation.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  BUS_WIDTH  APB write data.
- pstrb  out  MAX_DIM  APB write strobes.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.
- prdata  in  BUS_WIDTH  APB read data.
- busy  in  1  matmul busy flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = requester 0, lock cleared, timeout counter 0. Reset asserted mid-transfer aborts immediately; psel/penable drop asynchronously.
- FSM states:
  - IDLE → SETUP when an eligible req_valid is present.
  - SETUP → ACCESS unconditionally.
  - ACCESS → ACCESS while pready = 0.
  - ACCESS → DONE when pready = 1.
  - DONE → LOCK if the start condition holds, else → IDLE.
  - LOCK → IDLE on release.
- Eligibility: when not locked, both requesters are eligible. When locked, only the owner is eligible. A requester is ineligible in the cycle its req_done is high, so stale valid is never re-sampled.
- Round-robin:
  - Pointer names the preferred requester.
  - Both eligible → the pointer wins.
  - After every completed transfer the pointer moves to the other requester.
- Arbitration latency:
  - req_valid seen in IDLE at cycle N: grant and registered APB fields (latched from the winner's slices) appear at N+1 with psel=1, penable=0.
  - ACCESS at N+2: psel=1, penable=1, held until pready.
  - With pready=1 at cycle M: req_done[owner], req_rdata<=prdata and req_err<=pslverr are registered at M+1; psel/penable=0 at M+1.
  - Minimum 4 cycles per transfer.
- Start condition: completed transfer has pwrite=1, paddr==CTRL_ADDR, pstrb byte holding START_BIT set, pwdata[START_BIT]=1, pslverr=0. When it holds, locked=1, grant keeps the owner, and the timeout counter clears.
- LOCK phase A, waiting for busy rise:
  - Counter increments each cycle.
  - busy=1 moves to phase B.
  - Counter reaching START_TIMEOUT releases the lock.
- LOCK phase B: busy falling to 0 releases the lock.
- While locked the owner may issue further transfers (SETUP/ACCESS as usual), for example status reads. The lock persists across them and busy is tracked continuously. The other requester waits.
- Release: locked=0 and grant=0 next cycle. The pointer points to the non-owner.
- pslverr on the START write: no lock, normal completion with req_err=1.
- Requester dropping req_valid before req_done: illegal; an assertion flags it, and behaviour is undefined.

Decomposition:
- verif_package gains:
  - apb_req_t struct (addr, write, wdata, strb);
  - arb_state_e enum (IDLE, SETUP, ACCESS, DONE, LOCK);
  - constants CTRL_ADDR and START_BIT shared with the matmul model.
- One sub-module, matmul_lock_tracker: busy edge detection, start timeout counter, lock/release outputs.
- The top holds the FSM, round-robin pointer and APB registers.

Test Plan:
- Single read by req 0 at addr 0x0010, pready high in the first ACCESS → psel at N+1, penable at N+2, req_done[0] at N+3 with req_rdata=prdata.
- Both requesters valid from reset → req 0 granted first, then req 1. Alternation 0,1,0,1 over 4 continuous requests.
- Slave inserts 3 wait states → penable held 4 cycles; paddr/pwdata stable throughout; single req_done pulse.
- Req 1 writes 0x1 to CTRL_ADDR, busy rises after 5 cycles and falls after 40 → locked=1 throughout; req 0 stalls; req 1 status reads serviced; grant to req 0 only after busy falls.
- START write with busy never rising → lock released START_TIMEOUT cycles after DONE; START write returning pslverr=1 → no lock, req_err=1.
- Reset asserted during ACCESS → psel/penable/grant/locked 0 immediately; after release the first request is served by requester 0.

Source files
------------

// File: rtl/matmul_apb_arbiter_pkg.sv
// Shared types and constants for the two-requester matmul APB arbiter.
//   apb_req_t   : one requester's transfer fields (addr, write, wdata, strb)
//   arb_state_e : arbiter FSM states
//   CTRL_ADDR / START_BIT : location of the matmul START control bit
package matmul_apb_arbiter_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned BUS_W  = 64;
   localparam int unsigned STRB_W = 4;

   localparam logic [15:0] CTRL_ADDR = 16'h0000;
   localparam int unsigned START_BIT = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [BUS_W-1:0]  wdata;
      logic [STRB_W-1:0] strb;
   } apb_req_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE,
      LOCK
   } arb_state_e;

endpackage

// File: rtl/matmul_lock_tracker.sv
// Tracks the computation lock after a START write.
//   start     : one-cycle pulse, START write completed cleanly (sets lock)
//   busy      : matmul busy flag
//   locked    : registered lock flag
//   release_c : combinational, lock drops at the next edge
// Phase A waits for busy to rise (bounded by START_TIMEOUT),
// phase B waits for busy to fall.
module matmul_lock_tracker
   import matmul_apb_arbiter_pkg::*;
#(
   parameter int unsigned START_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic busy,
   output logic locked,
   output logic release_c
);

   localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

   logic             phase_b;
   logic [CNT_W-1:0] cnt;

   // Release on busy fall in phase B, or when the rise wait expires in phase A.
   assign release_c = locked & ~start &
                      (phase_b ? ~busy
                               : (~busy & (cnt == CNT_W'(START_TIMEOUT - 1))));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked  <= 1'b0;
         phase_b <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         locked  <= 1'b1;
         phase_b <= 1'b0;
         cnt     <= '0;
      end else if (release_c) begin
         locked  <= 1'b0;
         phase_b <= 1'b0;
         cnt     <= '0;
      end else if (locked && !phase_b) begin
         if (busy) phase_b <= 1'b1;
         else      cnt     <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/matmul_apb_arbiter.sv
// Two-requester round-robin APB master sharing the matmul slave.
//   req_*          : per-requester request slices, req_done/rdata/err completion
//   grant, locked  : current owner (one-hot) and computation lock
//   p*             : APB master signals towards the matmul slave
//   busy           : matmul busy flag, drives lock release
// rst_n is an asynchronous active-high reset.
module matmul_apb_arbiter
   import matmul_apb_arbiter_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH    = 16,
   parameter int unsigned           BUS_WIDTH     = 64,
   parameter int unsigned           MAX_DIM       = 4,
   parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR     = ADDR_WIDTH'(matmul_apb_arbiter_pkg::CTRL_ADDR),
   parameter int unsigned           START_BIT     = matmul_apb_arbiter_pkg::START_BIT,
   parameter int unsigned           START_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]              req_write,
   input  logic [2*BUS_WIDTH-1:0]  req_wdata,
   input  logic [2*MAX_DIM-1:0]    req_strb,
   output logic [1:0]              req_done,
   output logic [BUS_WIDTH-1:0]    req_rdata,
   output logic                    req_err,
   output logic [1:0]              grant,
   output logic                    locked,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [BUS_WIDTH-1:0]    pwdata,
   output logic [MAX_DIM-1:0]      pstrb,
   input  logic                    pready,
   input  logic                    pslverr,
   input  logic [BUS_WIDTH-1:0]    prdata,
   input  logic                    busy
);

   localparam logic [MAX_DIM-1:0]   START_STRB = MAX_DIM'(1) << (START_BIT / 8);
   localparam logic [BUS_WIDTH-1:0] START_DATA = BUS_WIDTH'(1) << START_BIT;

   arb_state_e state, state_n;
   logic       ptr;
   logic [1:0] elig_c;
   logic       win_c;
   logic       start_c;
   logic       release_c;

   // While locked only the owner may compete; a requester being acked is never re-sampled.
   assign elig_c  = req_valid & ~req_done & ({2{~locked}} | grant);
   assign win_c   = (elig_c == 2'b11) ? ptr : elig_c[1];

   // Clean START write to the control register just completed.
   assign start_c = (state == DONE) && pwrite && (paddr == CTRL_ADDR) &&
                    (|(pstrb & START_STRB)) && (|(pwdata & START_DATA)) && !req_err;

   matmul_lock_tracker #(
      .START_TIMEOUT (START_TIMEOUT)
   ) u_lock (
      .clk       (clk),
      .rst       (rst_n),
      .start     (start_c),
      .busy      (busy),
      .locked    (locked),
      .release_c (release_c)
   );

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (|elig_c) state_n = SETUP;
         SETUP:   state_n = ACCESS;
         ACCESS:  if (pready) state_n = DONE;
         DONE:    state_n = (start_c || (locked && !release_c)) ? LOCK : IDLE;
         LOCK: begin
            if (release_c)    state_n = IDLE;
            else if (|elig_c) state_n = SETUP;
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered APB fields, grant, completion and round-robin pointer.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         grant     <= '0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         req_done  <= '0;
         req_rdata <= '0;
         req_err   <= 1'b0;
         ptr       <= 1'b0;
      end else begin
         req_done <= '0;
         psel     <= (state_n == SETUP) || (state_n == ACCESS);
         penable  <= (state_n == ACCESS);
         if (state_n == SETUP) begin
            grant  <= win_c ? 2'b10 : 2'b01;
            paddr  <= win_c ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
            pwrite <= win_c ? req_write[1] : req_write[0];
            pwdata <= win_c ? req_wdata[BUS_WIDTH +: BUS_WIDTH] : req_wdata[0 +: BUS_WIDTH];
            pstrb  <= win_c ? req_strb[MAX_DIM +: MAX_DIM] : req_strb[0 +: MAX_DIM];
         end else if (state_n == IDLE) begin
            grant <= '0;
         end
         if (state == ACCESS && pready) begin
            req_done  <= grant;
            req_rdata <= prdata;
            req_err   <= pslverr;
         end
         if (state == DONE) ptr <= ~grant[1];
      end
   end

   // A granted requester must hold req_valid until its req_done.
   a_hold_valid: assert property (@(posedge clk) disable iff (rst_n)
      ((state == SETUP) || (state == ACCESS)) |-> |(req_valid & grant));

endmodule
